spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  Serial front end of the SPI-RAM subsystem, directly upstream of spi_ram.
//  Deserialises MOSI frames (MSB first) into 10-bit words for spi_ram (rx_data/rx_valid).
//  For read-data commands, accepts the byte spi_ram returns (tx_data/tx_valid) and shifts it out on MISO.
//  One clock domain; the SPI master drives MOSI/ss_n synchronous to clk.
// PARAMETERS
//  FRAME_W  10  rx word width: {cmd[1:0], payload[7:0]}
//  DATA_W    8  read-back byte width
// PORTS
//  clk       in   1        system clock, all logic on rising edge
//  rst       in   1        synchronous reset, active-high
//  ss_n      in   1        slave select, active-low; frame lives while low
//  mosi      in   1        serial data in, sampled every clk while frame active
//  miso      out  1        serial data out, MSB first
//  rx_data   out  FRAME_W  assembled word to spi_ram din
//  rx_valid  out  1        one-cycle strobe: rx_data valid
//  tx_data   in   DATA_W   read byte from spi_ram dout
//  tx_valid  in   1        tx_data valid strobe from spi_ram
// BEHAVIOUR
//  Reset: state=IDLE; miso=0, rx_data=0, rx_valid=0, bit counter=0, tx shift reg=0.
//  Commands (rx_data[9:8]): 00 wr addr, 01 wr data, 10 rd addr, 11 rd data.
//  FSM: IDLE, CHK_CMD, RX, DONE, WAIT_TX, TX.
//   IDLE: ss_n=0 -> CHK_CMD (no bit sampled on this edge).
//   CHK_CMD: sample mosi as bit 9, -> RX, counter=8.
//   RX: sample mosi into bit[counter]; after bit 0 -> rx_data updated,
//       rx_valid=1 next cycle for exactly one cycle; cmd==11 -> WAIT_TX else -> DONE.
//   DONE: ignore mosi until ss_n=1.
//   WAIT_TX: on tx_valid=1 latch tx_data, -> TX; no timeout, waits until ss_n=1.
//   TX: miso = tx bits 7..0, one bit per cycle starting cycle after latch; after bit 0 -> DONE, miso=0.
//  Latency: ss_n low at edge 0 -> bit9 at edge 1 -> bit0 at edge 10 -> rx_valid high after edge 10.
//  ss_n=1 in any non-IDLE state: next state IDLE, frame aborted, no rx_valid, miso=0.
//  ss_n=1 on the same edge bit 0 would be sampled: abort wins, no rx_valid.
//  tx_valid outside WAIT_TX: ignored. tx_valid same cycle as rx_valid: not possible from
//   spi_ram (min latency 1); if seen in WAIT_TX's first cycle, latch normally.
//  rx_data holds last completed word between frames; only rx_valid qualifies it.
//  rst mid-frame: all state/outputs to reset values on that edge; partial frame dropped.
//  miso=0 whenever not in TX.
// STRUCTURE
//  spi_pkg: state enum spi_state_e, cmd localparams CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA,
//   FRAME_W/DATA_W defaults.
//  One sub-module: spi_piso (DATA_W load/shift register, drives miso); SIPO and FSM stay in top.
// TESTING
//  1. rst=1 2 cycles -> miso=0, rx_valid=0, rx_data=10'h000, state IDLE.
//  2. ss_n low, mosi 00_1010_0101 -> rx_valid one cycle, rx_data=10'h0A5, 10 clks after ss_n fall.
//  3. Frame 10_0000_0011 then 11_0000_0000, model returns tx_data=8'h5C -> miso 0,1,0,1,1,1,0,0.
//  4. ss_n high after 6 bits of 01_... -> no rx_valid, IDLE next cycle; next frame decodes cleanly.
//  5. rst asserted during TX bit 3 -> miso=0 immediately after edge, state IDLE.
//  6. Extra 5 mosi bits after a 01 frame with ss_n low -> single rx_valid only, rx_data unchanged.
//  Bench: scoreboard against spi_ram read-back model; SVA for rx_valid one-cycle width.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the SPI-RAM subsystem.
package spi_pkg;

    localparam int unsigned FRAME_W_DEFAULT = 10;
    localparam int unsigned DATA_W_DEFAULT  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StRx,
        StDone,
        StWaitTx,
        StTx
    } spi_state_e;

endpackage

// File: rtl/spi_if.sv
// Serial pins plus the word-level handshake between the SPI slave and spi_ram.
interface spi_if
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) ();

    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    // Environment side: the SPI master pins together with the spi_ram return path.
    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_piso.sv
// Parallel-in serial-out register for read-back bytes; MSB leaves first on miso.
module spi_piso #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              oe,
    input  logic [DATA_W-1:0] din,
    output logic              miso
);

    logic [DATA_W-1:0] sreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din;
        end else if (shift) begin
            sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
        end
    end

    // Line is held low outside the transmit window.
    always_comb miso = oe & sreg_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises MSB-first frames into command words and returns read bytes on miso.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    spi_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_W);

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_load, tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;

        // Deselect aborts any frame in progress, including on the final bit's edge.
        if (state_q != StIdle && bus.ss_n) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!bus.ss_n) state_d = StChkCmd;
                end
                StChkCmd: begin
                    shreg_d[FRAME_W-1] = bus.mosi;
                    cnt_d              = CNT_W'(FRAME_W - 2);
                    state_d            = StRx;
                end
                StRx: begin
                    shreg_d[cnt_q] = bus.mosi;
                    if (cnt_q == '0) begin
                        rx_data_d  = shreg_d;
                        rx_valid_d = 1'b1;
                        state_d    = (shreg_d[FRAME_W-1 -: 2] == CMD_RD_DATA) ? StWaitTx : StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    // Trailing bits are ignored until deselect.
                end
                StWaitTx: begin
                    if (bus.tx_valid) begin
                        tx_load = 1'b1;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        state_d = StTx;
                    end
                end
                StTx: begin
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        tx_shift = 1'b1;
                        cnt_d    = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    spi_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .shift (tx_shift),
        .oe    (state_q == StTx),
        .din   (bus.tx_data),
        .miso  (bus.miso)
    );

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if with a small spi_ram read-back model on the far side.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_if bus ();

    spi_slave_if dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int fall_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
    end

    // spi_ram model: address register plus memory, answers rd-data commands.
    logic [7:0] mem [256];
    logic [7:0] addr;
    always @(negedge clk) begin
        bus.tx_valid = 1'b0;
        if (bus.rx_valid === 1'b1) begin
            case (bus.rx_data[9:8])
                CMD_WR_ADDR: addr = bus.rx_data[7:0];
                CMD_WR_DATA: mem[addr] = bus.rx_data[7:0];
                CMD_RD_ADDR: addr = bus.rx_data[7:0];
                default: begin
                    bus.tx_data  = mem[addr];
                    bus.tx_valid = 1'b1;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) bus.rx_valid |=> !bus.rx_valid)
    else begin
        failures++;
        $display("FAIL rx_valid_width: got 1 expected 0");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [9:0] f, input int nbits, input int extra);
        @(negedge clk);
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        fall_cyc = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.mosi = f[9-i];
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            bus.mosi = ~i[0];
        end
        @(negedge clk);
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Issues an 11_0000_0000 read; rst_at in 0..7 pulses reset while that miso bit is shown.
    task automatic read_frame(input int rst_at, output logic [7:0] got);
        logic [9:0] f;
        f   = 10'h300;
        got = '0;
        @(negedge clk);
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mosi = f[9-i];
        end
        @(negedge clk);
        check("rd_rx_valid", bus.rx_valid, 1);
        check("rd_rx_data", bus.rx_data, 10'h300);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            got[7-b] = bus.miso;
            if (b == rst_at) begin
                rst      = 1'b1;
                bus.ss_n = 1'b1;
                @(negedge clk);
                check("rst_tx_miso", bus.miso, 0);
                check("rst_tx_state", dut.state_q, StIdle);
                check("rst_tx_rx_data", bus.rx_data, 0);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        check("tx_done_miso", bus.miso, 0);
        check("tx_done_state", dut.state_q, StDone);
        bus.ss_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        int         extra;
        int         exp_valid;
        logic [9:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;

        vecs[0] = '{10'h0A5, 10, 0, 1, 10'h0A5};  // wr addr A5
        vecs[1] = '{10'h1C3,  6, 0, 0, 10'h0A5};  // abort after 6 bits
        vecs[2] = '{10'h13C, 10, 0, 1, 10'h13C};
        vecs[3] = '{10'h2F0,  9, 0, 0, 10'h13C};  // deselect on bit-0 edge
        vecs[4] = '{10'h155, 10, 5, 1, 10'h155};  // trailing bits ignored
        vecs[5] = '{10'h003, 10, 0, 1, 10'h003};  // wr addr 03
        vecs[6] = '{10'h15C, 10, 0, 1, 10'h15C};  // wr data 5C
        vecs[7] = '{10'h203, 10, 0, 1, 10'h203};  // rd addr 03

        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_miso", bus.miso, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_state", dut.state_q, StIdle);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            valid_cnt = 0;
            send_frame(vecs[v].frame, vecs[v].nbits, vecs[v].extra);
            check($sformatf("vec%0d_valid_cnt", v), valid_cnt, vecs[v].exp_valid);
            check($sformatf("vec%0d_rx_data", v), bus.rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d_state", v), dut.state_q, StIdle);
            if (vecs[v].exp_valid == 1) begin
                check($sformatf("vec%0d_latency", v), valid_cyc - fall_cyc, 10);
            end
        end

        valid_cnt = 0;
        read_frame(8, got);
        check("rd_miso_byte", got, 8'h5C);
        check("rd_valid_cnt", valid_cnt, 1);

        read_frame(4, got);
        check("rst_mid_tx_bits", got[7:4], 4'h5);

        valid_cnt = 0;
        send_frame(10'h0A5, 10, 0);
        check("recover_valid_cnt", valid_cnt, 1);
        check("recover_rx_data", bus.rx_data, 10'h0A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
